// File: rtl/cdc_2phase_src_arbiter.sv
// Round-robin arbiter that shares one CDC source channel between NumIn requesters.
// Packets stay contiguous up to MaxBurst beats, and a single output register drives the crossing.
module cdc_2phase_src_arbiter #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 8,
  parameter int IdxWidth  = $clog2(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumIn-1:0]           in_valid_i,
  output logic [NumIn-1:0]           in_ready_o,
  input  logic [NumIn*DataWidth-1:0] in_data_i,
  input  logic [NumIn-1:0]           in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [IdxWidth-1:0]        out_idx_o,
  output logic                       out_last_o
);
  localparam int CntW = (MaxBurst == 0) ? 1 : $clog2(MaxBurst + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [IdxWidth-1:0]   r_rr_ptr, w_rr_nxt;
  logic [IdxWidth-1:0]   r_lock_idx, w_lock_nxt;
  logic [CntW-1:0]       r_burst_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IdxWidth-1:0]   w_grant_idx;
  logic                  w_grant_vld;
  logic [NumIn-1:0]      w_grant_oh;
  logic                  w_load, w_accept, w_release;
  logic [DataWidth-1:0]  w_sel_data;

  logic                  r_vld_p1;
  logic [DataWidth-1:0]  r_data_p1;
  logic [IdxWidth-1:0]   r_idx_p1;
  logic                  r_last_p1;

  function automatic logic [IdxWidth-1:0] f_rr_idx(input logic [IdxWidth-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NumIn) s = s - NumIn;
    return IdxWidth'(s);
  endfunction

  function automatic logic [IdxWidth-1:0] f_wrap_inc(input logic [IdxWidth-1:0] idx);
    if (int'(idx) >= NumIn - 1) return '0;
    return idx + IdxWidth'(1);
  endfunction

  function automatic logic [CntW-1:0] f_sat_inc(input logic [CntW-1:0] cnt);
    if (cnt == {CntW{1'b1}}) return cnt;
    return cnt + CntW'(1);
  endfunction

  // Grant selection: fixed owner while locked, else first valid from rr pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (r_state == ST_LOCKED) begin
      w_grant_vld = 1'b1;
      w_grant_idx = r_lock_idx;
    end else begin
      for (int k = NumIn - 1; k >= 0; k--) begin
        if (in_valid_i[f_rr_idx(r_rr_ptr, k)]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = f_rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? ({{(NumIn-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  assign w_load     = !r_vld_p1 || out_ready_i;
  assign in_ready_o = (w_load && !rst_i) ? w_grant_oh : '0;
  assign w_accept   = |(in_valid_i & in_ready_o);
  assign w_sel_data = in_data_i[w_grant_idx*DataWidth +: DataWidth];
  assign w_cnt_inc  = f_sat_inc(r_burst_cnt);
  assign w_release  = in_last_i[w_grant_idx] ||
                      ((MaxBurst != 0) && (w_cnt_inc == CntW'(MaxBurst)));

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_idx;
    w_cnt_nxt   = r_burst_cnt;
    if (w_accept) begin
      if (w_release) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = f_wrap_inc(w_grant_idx);
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_lock_nxt  = w_grant_idx;
        // An unlimited burst never needs the count, so it stays parked at zero.
        w_cnt_nxt   = (MaxBurst == 0) ? '0 : w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lock_idx  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_lock_idx  <= w_lock_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Stage p1: output register toward the crossing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_idx_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else if (w_load) begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_data_p1 <= w_sel_data;
        r_idx_p1  <= w_grant_idx;
        r_last_p1 <= in_last_i[w_grant_idx];
      end
    end
  end

  assign out_valid_o = r_vld_p1;
  assign out_data_o  = r_data_p1;
  assign out_idx_o   = r_idx_p1;
  assign out_last_o  = r_last_p1;

endmodule

// File: tb/tb_cdc_2phase_src_arbiter.sv
// Randomized scoreboard bench for cdc_2phase_src_arbiter (NumIn=4, MaxBurst=4).
module tb_cdc_2phase_src_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid, in_ready, in_last;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready, out_last;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;

  always #5 clk = ~clk;

  cdc_2phase_src_arbiter #(.NumIn(N), .DataWidth(DW), .MaxBurst(MB)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_last_o(out_last)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passed = 0;

  // Reference model: arbitration owner, round-robin start, burst length, output occupancy.
  bit m_locked;
  int m_lock, m_rr, m_cnt;
  bit m_ovalid;

  // Requester packet sources.
  int rem[N];
  int seq[N];
  int acc_idx;
  bit was_rst, prev_rst;
  int p_start, p_gap, ready_pct, maxlen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_grant();
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_lock = 0; m_rr = 0; m_cnt = 0; m_ovalid = 0;
    exp_q.delete();
    acc_idx = -1;
  endtask

  task automatic step(input bit r);
    int    g, ncnt;
    bit    load, acc;
    logic [N-1:0] exp_rdy;
    beat_t b;
    @(negedge clk);
    prev_rst = was_rst;
    rst = r;
    if (r) begin
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = 1'($urandom);
      for (int i = 0; i < N; i++) rem[i] = 0;
      was_rst = 1;
    end else begin
      if (was_rst) begin
        in_valid = '0;
        was_rst  = 0;
      end
      if (acc_idx >= 0) begin
        in_valid[acc_idx] = 1'b0;
        rem[acc_idx]--;
        seq[acc_idx]++;
      end
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i]) begin
          if (rem[i] == 0 && $urandom_range(0, 99) < p_start) rem[i] = $urandom_range(1, maxlen);
          if (rem[i] > 0 && $urandom_range(0, 99) >= p_gap) begin
            in_valid[i]          = 1'b1;
            in_data[i*DW +: DW]  = DW'((i << 14) | (seq[i] & 'h3fff));
            in_last[i]           = (rem[i] == 1);
          end
        end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    if (r) begin
      check("rst_in_ready", 64'(in_ready), 64'(0));
      if (prev_rst) begin
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_data, out_idx, out_last}), 64'(0));
      end
      model_reset();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_ovalid));
      g       = exp_grant();
      load    = !m_ovalid || out_ready;
      exp_rdy = (load && g >= 0) ? (N'(1) << g) : '0;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      acc = load && g >= 0 && in_valid[g];
      if (load) m_ovalid = acc;
      acc_idx = acc ? g : -1;
      if (acc) begin
        b.d   = in_data[g*DW +: DW];
        b.idx = IW'(g);
        b.l   = in_last[g];
        exp_q.push_back(b);
        ncnt = m_cnt + 1;
        if (in_last[g] || ncnt == MB) begin
          m_locked = 0; m_rr = (g + 1) % N; m_cnt = 0;
        end else begin
          m_locked = 1; m_lock = g; m_cnt = ncnt;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every downstream handshake, checks hold while stalled.
  initial begin
    bit    stalled;
    beat_t held, cur, e;
    stalled = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) begin
        stalled = 0;
      end else begin
        cur = '{d: out_data, idx: out_idx, l: out_last};
        if (stalled) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check("stall_hold", 64'(cur), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("dup_beat", 64'(cur), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
        end
        stalled = out_valid && !out_ready;
        held    = cur;
      end
    end
  end

  initial begin
    int pending;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    model_reset();
    was_rst = 1; prev_rst = 1;
    p_start = 0; p_gap = 0; ready_pct = 100; maxlen = 1;
    rst = 1'b1;
    in_valid = N'($urandom); in_last = N'($urandom);
    in_data = {$urandom, $urandom}; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    repeat (2) step(1'b1);
    repeat (4) step(1'b0);

    p_start = 100; maxlen = 1;
    repeat (40) step(1'b0);

    maxlen = 7;
    repeat (200) step(1'b0);

    p_start = 50; p_gap = 20; ready_pct = 60;
    repeat (600) step(1'b0);

    for (int c = 0; c < 400; c++) step($urandom_range(0, 39) == 0);

    p_start = 0; p_gap = 0; ready_pct = 100;
    for (int c = 0; c < 300; c++) begin
      step(1'b0);
      pending = 0;
      for (int i = 0; i < N; i++) pending += rem[i];
      if (pending == 0 && exp_q.size() == 0 && !m_ovalid && in_valid == '0) break;
    end
    pending = 0;
    for (int i = 0; i < N; i++) pending += rem[i];
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_pending", 64'(pending), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
